// File: rtl/stonyman_pkg.sv
// Shared state encoding, chip pointer values and strobe sequencing tables for the Stonyman frame sequencer.
// Pure definitions: no timing and no backpressure of its own.
package stonyman_pkg;

    typedef enum logic [3:0] {
        IDLE, ROW_PTR, COL_PTR, SETTLE, CAPTURE, WAIT_DONE, COL_INC, ROW_INC, DONE
    } state_t;

    // resp parks the chip pointer on COLSEL; one incp moves it to ROWSEL.
    typedef enum logic {COLSEL = 1'b0, ROWSEL = 1'b1} chip_ptr_t;

    // One-hot strobe select, bit order {incv, resv, incp, resp}
    typedef logic [3:0] strobe_t;
    localparam strobe_t STB_RESP = 4'b0001;
    localparam strobe_t STB_INCP = 4'b0010;
    localparam strobe_t STB_RESV = 4'b0100;
    localparam strobe_t STB_INCV = 4'b1000;

    function automatic strobe_t strobe_for(state_t st, logic [1:0] step);
        strobe_t s;
        s = STB_INCV;
        case (st)
            ROW_PTR: s = (step == 2'd0) ? STB_RESP : (step == 2'd1) ? STB_INCP : STB_RESV;
            COL_PTR: s = (step == 2'd0) ? STB_RESP : STB_RESV;
            ROW_INC: s = (step == 2'd0) ? STB_RESP : (step == 2'd1) ? STB_INCP : STB_INCV;
            default: s = STB_INCV;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] last_step(state_t st);
        logic [1:0] n;
        n = 2'd0;
        case (st)
            ROW_PTR: n = 2'd2;
            COL_PTR: n = 2'd1;
            ROW_INC: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stonyman_frame_sequencer_if.sv
// Frame control, ADC handshake, FIFO back-pressure, chip strobes and pixel coordinates.
// master = sequencer side, slave = chip/ADC/FIFO environment.
interface stonyman_frame_sequencer_if;
    logic       frame_start;
    logic       adc_capture_done;
    logic       fifo_full;
    logic       adc_capture_start;
    logic       resp;
    logic       incp;
    logic       resv;
    logic       incv;
    logic       frame_busy;
    logic       frame_done;
    logic [6:0] pixel_row;
    logic [6:0] pixel_col;

    modport master (
        input  frame_start, adc_capture_done, fifo_full,
        output adc_capture_start, resp, incp, resv, incv,
               frame_busy, frame_done, pixel_row, pixel_col
    );

    modport slave (
        output frame_start, adc_capture_done, fifo_full,
        input  adc_capture_start, resp, incp, resv, incv,
               frame_busy, frame_done, pixel_row, pixel_col
    );
endinterface

// File: rtl/stonyman_pulse_gen.sv
// Drives one strobe high PULSE_CYCLES then low PULSE_CYCLES; strobe rises the cycle after req.
// rdy pulses one cycle at the end of the low phase; req is ignored while a pulse is in flight.
module stonyman_pulse_gen
    import stonyman_pkg::*;
#(
    parameter int PULSE_CYCLES = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    req,
    input  strobe_t sel,
    output logic    resp,
    output logic    incp,
    output logic    resv,
    output logic    incv,
    output logic    rdy
);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    logic       busy;
    logic       high;
    logic [7:0] cnt;
    strobe_t    stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            high <= 1'b0;
            cnt  <= 8'd0;
            stb  <= '0;
            rdy  <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (!busy) begin
                if (req) begin
                    busy <= 1'b1;
                    high <= 1'b1;
                    cnt  <= PULSE_LAST;
                    stb  <= sel;
                end
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else if (high) begin
                high <= 1'b0;
                stb  <= '0;
                cnt  <= PULSE_LAST;
            end else begin
                busy <= 1'b0;
                rdy  <= 1'b1;
            end
        end
    end

    assign {incv, resv, incp, resp} = stb;

endmodule

// File: rtl/stonyman_frame_sequencer.sv
// Walks the Stonyman pixel array one pixel at a time: strobes the pointers, settles, triggers the ADC.
// Captures stall in SETTLE while fifo_full is high; frame_start is ignored while a frame is busy.
module stonyman_frame_sequencer
    import stonyman_pkg::*;
#(
    parameter int ROWS          = 112,
    parameter int COLS          = 112,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    stonyman_frame_sequencer_if.master      bus
);
    localparam logic [6:0] LAST_ROW    = 7'(ROWS - 1);
    localparam logic [6:0] LAST_COL    = 7'(COLS - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] step;
    logic [7:0] timer;
    logic       pg_req;
    strobe_t    pg_sel;
    logic       pg_rdy;
    logic       capture_start;
    logic       frame_busy;
    logic       frame_done;
    logic [6:0] pixel_row;
    logic [6:0] pixel_col;
    logic       stb_resp, stb_incp, stb_resv, stb_incv;

    stonyman_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse_gen (
        .clk   (clk),
        .reset (reset),
        .req   (pg_req),
        .sel   (pg_sel),
        .resp  (stb_resp),
        .incp  (stb_incp),
        .resv  (stb_resv),
        .incv  (stb_incv),
        .rdy   (pg_rdy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            step          <= 2'd0;
            timer         <= 8'd0;
            pg_req        <= 1'b0;
            pg_sel        <= '0;
            capture_start <= 1'b0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            pixel_row     <= 7'd0;
            pixel_col     <= 7'd0;
        end else begin
            pg_req <= 1'b0;
            case (state)
                IDLE: if (bus.frame_start) begin
                    frame_busy <= 1'b1;
                    state      <= ROW_PTR;
                    step       <= 2'd0;
                    pg_req     <= 1'b1;
                    pg_sel     <= strobe_for(ROW_PTR, 2'd0);
                end
                // Each strobe state steps through its sequence, advancing on the pulse generator's rdy
                ROW_PTR, COL_PTR, COL_INC, ROW_INC: if (pg_rdy) begin
                    if (step != last_step(state)) begin
                        step   <= step + 2'd1;
                        pg_req <= 1'b1;
                        pg_sel <= strobe_for(state, step + 2'd1);
                    end else begin
                        step <= 2'd0;
                        case (state)
                            ROW_PTR: begin
                                pixel_row <= 7'd0;
                                state     <= COL_PTR;
                                pg_req    <= 1'b1;
                                pg_sel    <= strobe_for(COL_PTR, 2'd0);
                            end
                            COL_PTR: begin
                                pixel_col <= 7'd0;
                                state     <= SETTLE;
                                timer     <= 8'd0;
                            end
                            COL_INC: begin
                                pixel_col <= pixel_col + 7'd1;
                                state     <= SETTLE;
                                timer     <= 8'd0;
                            end
                            default: begin
                                pixel_row <= pixel_row + 7'd1;
                                state     <= COL_PTR;
                                pg_req    <= 1'b1;
                                pg_sel    <= strobe_for(COL_PTR, 2'd0);
                            end
                        endcase
                    end
                end
                SETTLE: begin
                    if (timer != SETTLE_LAST) begin
                        timer <= timer + 8'd1;
                    end else if (!bus.fifo_full) begin
                        state         <= CAPTURE;
                        capture_start <= 1'b1;
                    end
                end
                CAPTURE: begin
                    capture_start <= 1'b0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: if (bus.adc_capture_done) begin
                    if (pixel_col < LAST_COL) begin
                        state  <= COL_INC;
                        pg_req <= 1'b1;
                        pg_sel <= STB_INCV;
                    end else if (pixel_row < LAST_ROW) begin
                        state  <= ROW_INC;
                        pg_req <= 1'b1;
                        pg_sel <= strobe_for(ROW_INC, 2'd0);
                    end else begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.adc_capture_start = capture_start;
    assign bus.resp              = stb_resp;
    assign bus.incp              = stb_incp;
    assign bus.resv              = stb_resv;
    assign bus.incv              = stb_incv;
    assign bus.frame_busy        = frame_busy;
    assign bus.frame_done        = frame_done;
    assign bus.pixel_row         = pixel_row;
    assign bus.pixel_col         = pixel_col;

endmodule

// File: tb/tb_stonyman_frame_sequencer.sv
// Bench for the frame sequencer: a 2x3 array instance and a degenerate 1x1 instance, each with a 10-cycle ADC model.
module tb_stonyman_frame_sequencer;
    import stonyman_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stonyman_frame_sequencer_if bus();
    stonyman_frame_sequencer_if bus1();

    stonyman_frame_sequencer #(.ROWS(2), .COLS(3), .PULSE_CYCLES(2), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    stonyman_frame_sequencer #(.ROWS(1), .COLS(1), .PULSE_CYCLES(2), .SETTLE_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    typedef enum int {EV_RESP, EV_INCP, EV_RESV, EV_INCV, EV_CAP, EV_DONE} ev_kind_e;
    typedef struct { ev_kind_e kind; int row; int col; } ev_t;

    ev_t  q0[$];
    ev_t  q1[$];
    ev_t  exp_full[21];
    ev_t  exp_one[7];
    int   exp_cnt[6];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   shape_en = 1'b0;

    logic [20:0] outs0, outs1;
    assign outs0 = {bus.adc_capture_start, bus.resp, bus.incp, bus.resv, bus.incv,
                    bus.frame_busy, bus.frame_done, bus.pixel_row, bus.pixel_col};
    assign outs1 = {bus1.adc_capture_start, bus1.resp, bus1.incp, bus1.resv, bus1.incv,
                    bus1.frame_busy, bus1.frame_done, bus1.pixel_row, bus1.pixel_col};

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic ev_t mk(ev_kind_e k, int r, int c);
        ev_t e;
        e.kind = k;
        e.row  = r;
        e.col  = c;
        return e;
    endfunction

    function automatic int enc(ev_t e);
        return (int'(e.kind) << 16) | ((e.kind == EV_CAP) ? ((e.row << 8) | e.col) : 0);
    endfunction

    // ADC models: adc_capture_done ten cycles after each adc_capture_start
    initial begin
        bus.adc_capture_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.adc_capture_start) begin
                repeat (10) @(negedge clk);
                bus.adc_capture_done = 1'b1;
                @(negedge clk);
                bus.adc_capture_done = 1'b0;
            end
        end
    end

    initial begin
        bus1.adc_capture_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.adc_capture_start) begin
                repeat (10) @(negedge clk);
                bus1.adc_capture_done = 1'b1;
                @(negedge clk);
                bus1.adc_capture_done = 1'b0;
            end
        end
    end

    // Event logger and strobe shape checker for the 2x3 instance
    logic [3:0] s0, prev_s0 = 4'b0;
    int         hi_len = 0;
    int         gap = 99;
    always @(negedge clk) begin
        s0 = {bus.incv, bus.resv, bus.incp, bus.resp};
        if (reset) begin
            prev_s0 = 4'b0;
            hi_len  = 0;
            gap     = 99;
        end else begin
            if ((s0 & ~prev_s0) != 4'b0) begin
                if (shape_en) begin
                    chk("strobe_onehot", $countones(s0), 1);
                    chk("strobe_low_gap_ge2", int'(gap >= 2), 1);
                end
                hi_len = 1;
            end else if (s0 != 4'b0) begin
                hi_len++;
            end
            if (s0 == 4'b0) begin
                if (prev_s0 != 4'b0) begin
                    if (shape_en) chk("strobe_high_len", hi_len, 2);
                    gap = 1;
                end else begin
                    gap++;
                end
            end
            for (int i = 0; i < 4; i++)
                if (s0[i] && !prev_s0[i]) q0.push_back(mk(ev_kind_e'(i), 0, 0));
            if (bus.adc_capture_start) q0.push_back(mk(EV_CAP, int'(bus.pixel_row), int'(bus.pixel_col)));
            if (bus.frame_done) q0.push_back(mk(EV_DONE, 0, 0));
            prev_s0 = s0;
        end
    end

    logic [3:0] s1, prev_s1 = 4'b0;
    always @(negedge clk) begin
        s1 = {bus1.incv, bus1.resv, bus1.incp, bus1.resp};
        if (reset) begin
            prev_s1 = 4'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (s1[i] && !prev_s1[i]) q1.push_back(mk(ev_kind_e'(i), 0, 0));
            if (bus1.adc_capture_start) q1.push_back(mk(EV_CAP, int'(bus1.pixel_row), int'(bus1.pixel_col)));
            if (bus1.frame_done) q1.push_back(mk(EV_DONE, 0, 0));
            prev_s1 = s1;
        end
    end

    task automatic start0();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.frame_done) break;
        end
        chk({tag, "_done_seen"}, int'(i < 3000), 1);
        chk({tag, "_busy_low_at_done"}, int'(bus.frame_busy), 0);
    endtask

    task automatic compare_frame0(input string tag);
        int cnt[6];
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        chk({tag, "_event_count"}, q0.size(), 21);
        for (int i = 0; i < 21; i++)
            if (i < q0.size()) chk($sformatf("%s_ev%0d", tag, i), enc(q0[i]), enc(exp_full[i]));
        foreach (q0[i]) cnt[int'(q0[i].kind)]++;
        for (int k = 0; k < 6; k++) chk($sformatf("%s_kind%0d_total", tag, k), cnt[k], exp_cnt[k]);
    endtask

    initial begin
        int i;
        int early;
        int nz;

        // Expected event order for a 2x3 frame
        exp_full[0]  = mk(EV_RESP, 0, 0);  exp_full[1]  = mk(EV_INCP, 0, 0);
        exp_full[2]  = mk(EV_RESV, 0, 0);  exp_full[3]  = mk(EV_RESP, 0, 0);
        exp_full[4]  = mk(EV_RESV, 0, 0);  exp_full[5]  = mk(EV_CAP, 0, 0);
        exp_full[6]  = mk(EV_INCV, 0, 0);  exp_full[7]  = mk(EV_CAP, 0, 1);
        exp_full[8]  = mk(EV_INCV, 0, 0);  exp_full[9]  = mk(EV_CAP, 0, 2);
        exp_full[10] = mk(EV_RESP, 0, 0);  exp_full[11] = mk(EV_INCP, 0, 0);
        exp_full[12] = mk(EV_INCV, 0, 0);  exp_full[13] = mk(EV_RESP, 0, 0);
        exp_full[14] = mk(EV_RESV, 0, 0);  exp_full[15] = mk(EV_CAP, 1, 0);
        exp_full[16] = mk(EV_INCV, 0, 0);  exp_full[17] = mk(EV_CAP, 1, 1);
        exp_full[18] = mk(EV_INCV, 0, 0);  exp_full[19] = mk(EV_CAP, 1, 2);
        exp_full[20] = mk(EV_DONE, 0, 0);
        // resp, incp, resv, incv, capture, done
        exp_cnt = '{4, 2, 3, 5, 6, 1};
        exp_one[0] = mk(EV_RESP, 0, 0);  exp_one[1] = mk(EV_INCP, 0, 0);
        exp_one[2] = mk(EV_RESV, 0, 0);  exp_one[3] = mk(EV_RESP, 0, 0);
        exp_one[4] = mk(EV_RESV, 0, 0);  exp_one[5] = mk(EV_CAP, 0, 0);
        exp_one[6] = mk(EV_DONE, 0, 0);

        reset = 1'b1;
        bus.frame_start  = 1'b0;
        bus.fifo_full    = 1'b0;
        bus1.frame_start = 1'b0;
        bus1.fifo_full   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(outs0), 0);
        chk("reset_state", int'(dut.state), int'(IDLE));
        chk("reset_outputs_1x1", int'(outs1), 0);
        reset = 1'b0;
        @(negedge clk);

        // Plain full frame
        shape_en = 1'b1;
        q0.delete();
        start0();
        wait_done0("frameA");
        @(negedge clk);
        compare_frame0("frameA");

        // FIFO full across the second settle expiry
        q0.delete();
        start0();
        for (i = 0; i < 3000; i++) begin
            if (bus.incv) break;
            @(negedge clk);
        end
        chk("bp_first_incv_seen", int'(i < 3000), 1);
        bus.fifo_full = 1'b1;
        early = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.adc_capture_start) early++;
        end
        bus.fifo_full = 1'b0;
        chk("bp_no_capture_while_full", early, 0);
        @(negedge clk);
        chk("bp_capture_after_release", int'(bus.adc_capture_start), 1);
        chk("bp_capture_col", int'(bus.pixel_col), 1);
        wait_done0("frameB");
        @(negedge clk);
        compare_frame0("frameB");

        // Second frame_start while busy is dropped; one right after frame_done is taken
        q0.delete();
        start0();
        for (i = 0; i < 3000; i++) begin
            if (bus.adc_capture_start) break;
            @(negedge clk);
        end
        chk("busy_first_capture_seen", int'(i < 3000), 1);
        start0();
        wait_done0("frameC");
        @(negedge clk);
        compare_frame0("frameC");
        q0.delete();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        chk("restart_busy", int'(bus.frame_busy), 1);
        chk("restart_resp_not_yet", int'(bus.resp), 0);
        @(negedge clk);
        chk("restart_resp_rises", int'(bus.resp), 1);
        wait_done0("frameD");
        @(negedge clk);
        compare_frame0("frameD");

        // Reset while waiting on the ADC for pixel (0,2)
        start0();
        for (i = 0; i < 3000; i++) begin
            if (bus.adc_capture_start && bus.pixel_col == 7'd2) break;
            @(negedge clk);
        end
        chk("rst_pixel02_seen", int'(i < 3000), 1);
        repeat (2) @(negedge clk);
        shape_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", int'(outs0), 0);
        chk("rst_mid_state", int'(dut.state), int'(IDLE));
        reset = 1'b0;
        nz = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (outs0 != 21'd0) nz++;
        end
        chk("rst_late_done_ignored", nz, 0);
        shape_en = 1'b1;
        q0.delete();
        start0();
        wait_done0("frameE");
        @(negedge clk);
        compare_frame0("frameE");

        // 1x1 frame
        q1.delete();
        bus1.frame_start = 1'b1;
        @(negedge clk);
        bus1.frame_start = 1'b0;
        for (i = 0; i < 3000; i++) begin
            if (bus1.frame_done) break;
            @(negedge clk);
        end
        chk("one_done_seen", int'(i < 3000), 1);
        @(negedge clk);
        chk("one_event_count", q1.size(), 7);
        for (int k = 0; k < 7; k++)
            if (k < q1.size()) chk($sformatf("one_ev%0d", k), enc(q1[k]), enc(exp_one[k]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
